// File: rtl/pixel_arbiter.sv
// -----------------------------------------------------------------------------
// pixel_arbiter
//   Round-robin burst arbiter between NUM_SRC pixel drawers and the VGA adapter.
//   A source is granted for a whole shape (until its last pixel is accepted);
//   accepted pixels reach the registered x/y/colour/plot outputs one cycle later.
//
// Parameters
//   NUM_SRC : number of pixel sources (2..8)
//   GW      : width of grant index register, 2**GW >= NUM_SRC
//
// Ports
//   clock, reset_n        : clock, asynchronous active-low reset
//   src_req / src_last    : per-source pixel valid / last-pixel-of-shape flag
//   src_x/src_y/src_colour: flattened per-source pixel fields (8/7/3 bits each)
//   src_ack               : combinational accept strobe, granted source only
//   src_done              : one-cycle pulse coincident with a shape's final plot
//   x, y, colour, plot    : registered pixel stream to the VGA adapter
//   busy                  : high while a burst is granted
//
// Optional feature (macro PIXEL_ARB_BOUNDS_CHECK_EN)
//   Accepted pixels outside 160x120 are acked and count toward last/done but
//   are not plotted and do not update x/y/colour.
// -----------------------------------------------------------------------------
module pixel_arbiter #(
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned GW      = 3
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [NUM_SRC-1:0]     src_req,
   input  logic [NUM_SRC-1:0]     src_last,
   input  logic [8*NUM_SRC-1:0]   src_x,
   input  logic [7*NUM_SRC-1:0]   src_y,
   input  logic [3*NUM_SRC-1:0]   src_colour,
   output logic [NUM_SRC-1:0]     src_ack,
   output logic [NUM_SRC-1:0]     src_done,
   output logic [7:0]             x,
   output logic [6:0]             y,
   output logic [2:0]             colour,
   output logic                   plot,
   output logic                   busy
);

   localparam int unsigned XW = 8;
   localparam int unsigned YW = 7;
   localparam int unsigned CW = 3;

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

   state_e               state_q;
   logic [GW-1:0]        grant_q;
   logic [GW-1:0]        last_grant_q;
   logic [XW-1:0]        x_q;
   logic [YW-1:0]        y_q;
   logic [CW-1:0]        colour_q;
   logic                 plot_q;
   logic                 busy_q;
   logic [NUM_SRC-1:0]   done_q;

   logic                 win_found;
   logic [GW-1:0]        win_idx;
   logic [XW-1:0]        sel_x;
   logic [YW-1:0]        sel_y;
   logic [CW-1:0]        sel_colour;
   logic                 sel_last;
   logic                 accept;
   logic                 plot_ok;

   // Round-robin winner: first requester after last_grant_q. Scanning offsets
   // from farthest to nearest lets the nearest requester overwrite the result.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = int'(NUM_SRC); k >= 1; k--) begin
         for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (src_req[i] && (((int'(last_grant_q) + k) % int'(NUM_SRC)) == i)) begin
               win_found = 1'b1;
               win_idx   = GW'(i);
            end
         end
      end
   end

   // Granted-source field mux and accept strobe; only the granted source can be acked.
   always_comb begin
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      sel_last   = 1'b0;
      src_ack    = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (grant_q == GW'(i)) begin
            sel_x      = src_x[XW*i +: XW];
            sel_y      = src_y[YW*i +: YW];
            sel_colour = src_colour[CW*i +: CW];
            sel_last   = src_last[i];
            src_ack[i] = (state_q == BURST) && src_req[i];
         end
      end
   end

   assign accept = |src_ack;

`ifdef PIXEL_ARB_BOUNDS_CHECK_EN
   // Off-screen pixels (e.g. wrapped stair rows) are swallowed, not drawn.
   assign plot_ok = (sel_x <= XW'(159)) && (sel_y <= YW'(119));
`else
   assign plot_ok = 1'b1;
`endif

   // Arbitration FSM with registered pixel stream and strobes.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_SRC - 1);
         x_q          <= '0;
         y_q          <= '0;
         colour_q     <= '0;
         plot_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= '0;
      end else begin
         plot_q <= 1'b0;
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  grant_q <= win_idx;
                  state_q <= BURST;
                  busy_q  <= 1'b1;
               end
            end
            BURST: begin
               if (accept) begin
                  if (plot_ok) begin
                     x_q      <= sel_x;
                     y_q      <= sel_y;
                     colour_q <= sel_colour;
                     plot_q   <= 1'b1;
                  end
                  if (sel_last) begin
                     // src_ack is one-hot on the granted source here
                     done_q       <= src_ack;
                     last_grant_q <= grant_q;
                     state_q      <= IDLE;
                     busy_q       <= 1'b0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign x        = x_q;
   assign y        = y_q;
   assign colour   = colour_q;
   assign plot     = plot_q;
   assign busy     = busy_q;
   assign src_done = done_q;

endmodule

// File: tb/tb_pixel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pixel_arbiter
//   Directed bench for pixel_arbiter (NUM_SRC=2). Each stimulus cycle states
//   the expected ack/busy; every expected ack pushes the predicted plot/done
//   event (with its due cycle) onto a scoreboard popped by an output monitor.
// -----------------------------------------------------------------------------
module tb_pixel_arbiter;

   localparam int unsigned NS = 2;

   logic            clock = 1'b0;
   logic            reset_n;
   logic [NS-1:0]   src_req, src_last, src_ack, src_done;
   logic [8*NS-1:0] src_x;
   logic [7*NS-1:0] src_y;
   logic [3*NS-1:0] src_colour;
   logic [7:0]      x;
   logic [6:0]      y;
   logic [2:0]      colour;
   logic            plot, busy;

   pixel_arbiter #(.NUM_SRC(NS), .GW(3)) dut (
      .clock(clock), .reset_n(reset_n),
      .src_req(src_req), .src_last(src_last),
      .src_x(src_x), .src_y(src_y), .src_colour(src_colour),
      .src_ack(src_ack), .src_done(src_done),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic       plot;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic [1:0] done;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_err = 0;
   logic mon_en = 1'b0;

   logic [7:0] px[NS];
   logic [6:0] py[NS];
   logic [2:0] pc[NS];
   logic       preq[NS];
   logic       plast[NS];
   int         cnt[NS];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   task automatic apply();
      for (int s = 0; s < int'(NS); s++) begin
         src_req[s]          = preq[s];
         src_last[s]         = plast[s];
         src_x[8*s +: 8]     = px[s];
         src_y[7*s +: 7]     = py[s];
         src_colour[3*s +: 3] = pc[s];
      end
   endtask

   task automatic set_src(input int s, input logic req, input logic last,
                          input logic [7:0] xv, input logic [6:0] yv, input logic [2:0] cv);
      preq[s] = req; plast[s] = last; px[s] = xv; py[s] = yv; pc[s] = cv;
      apply();
   endtask

   function automatic logic exp_plot(input logic [7:0] xv, input logic [6:0] yv);
`ifdef PIXEL_ARB_BOUNDS_CHECK_EN
      return (xv <= 8'd159) && (yv <= 7'd119);
`else
      return 1'b1;
`endif
   endfunction

   // One clock of stimulus: check ack/busy mid-cycle, predict the outputs it causes.
   task automatic step(input logic [1:0] eack, input logic ebusy, input string nm);
      exp_t e;
      @(negedge clock);
      chk({nm, " ack"}, 32'(src_ack), 32'(eack));
      chk({nm, " busy"}, 32'(busy), 32'(ebusy));
      for (int s = 0; s < int'(NS); s++) begin
         if (eack[s]) begin
            e.cyc  = cyc + 1;
            e.plot = exp_plot(px[s], py[s]);
            e.x    = px[s];
            e.y    = py[s];
            e.c    = pc[s];
            e.done = plast[s] ? 2'(1 << s) : 2'b00;
            if (e.plot || plast[s]) sbq.push_back(e);
         end
      end
      @(posedge clock);
      #1;
   endtask

   // Output monitor: every plot/done must match the oldest prediction on its due cycle.
   always @(negedge clock) begin
      exp_t e;
      if (reset_n && mon_en) begin
         while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            chk("missed output, due cycle", 32'(cyc), 32'(e.cyc));
         end
         if (plot || (|src_done)) begin
            if (sbq.size() == 0) begin
               chk("unexpected plot/done", 32'({plot, src_done}), 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("output cycle", 32'(cyc), 32'(e.cyc));
               chk("plot", 32'(plot), 32'(e.plot));
               chk("src_done", 32'(src_done), 32'(e.done));
               if (e.plot) begin
                  chk("x", 32'(x), 32'(e.x));
                  chk("y", 32'(y), 32'(e.y));
                  chk("colour", 32'(colour), 32'(e.c));
               end
            end
         end
      end
   end

   task automatic check_cleared(input string nm);
      chk({nm, " plot"}, 32'(plot), 32'd0);
      chk({nm, " x"}, 32'(x), 32'd0);
      chk({nm, " y"}, 32'(y), 32'd0);
      chk({nm, " colour"}, 32'(colour), 32'd0);
      chk({nm, " busy"}, 32'(busy), 32'd0);
      chk({nm, " src_ack"}, 32'(src_ack), 32'd0);
      chk({nm, " src_done"}, 32'(src_done), 32'd0);
   endtask

   initial begin
      // ---------------- reset with all sources requesting ----------------
      reset_n = 1'b0;
      set_src(0, 1'b1, 1'b1, 8'd10, 7'd20, 3'd1);
      set_src(1, 1'b1, 1'b1, 8'd30, 7'd40, 3'd2);
      repeat (3) @(negedge clock);
      check_cleared("reset");
      mon_en  = 1'b1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      step(2'b01, 1'b1, "first grant src0");
      step(2'b00, 1'b0, "arb gap");
      step(2'b10, 1'b1, "rr grant src1");
      set_src(0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      set_src(1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      step(2'b00, 1'b0, "idle");

      // ---------------- contention: 3-pixel shapes from both ----------------
      for (int s = 0; s < int'(NS); s++) begin
         cnt[s] = 0;
         set_src(s, 1'b1, 1'b0, 8'(s * 50), 7'(s * 10), 3'(s + 2));
      end
      step(2'b00, 1'b0, "cont arb");
      for (int b = 0; b < 4; b++) begin
         int s;
         s = b % 2;
         for (int p = 0; p < 3; p++) begin
            set_src(s, 1'b1, (cnt[s] == 2), 8'(s * 50 + cnt[s] + b), 7'(s * 10 + cnt[s]), 3'(s + 2));
            step(2'(1 << s), 1'b1, "cont burst");
            cnt[s] = (cnt[s] + 1) % 3;
         end
         if (b < 3) step(2'b00, 1'b0, "cont gap");
      end
      set_src(0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      set_src(1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      step(2'b00, 1'b0, "cont end");

      // ---------------- single 200-pixel burst, 40x5 block ----------------
      set_src(0, 1'b1, 1'b0, 8'd60, 7'd40, 3'b100);
      step(2'b00, 1'b0, "blk arb");
      for (int p = 0; p < 200; p++) begin
         set_src(0, 1'b1, (p == 199), 8'(60 + p % 40), 7'(40 + p / 40), 3'b100);
         step(2'b01, 1'b1, "blk pixel");
      end
      set_src(0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      step(2'b00, 1'b0, "blk end");

      // ---------------- stall of src1 with src0 waiting ----------------
      set_src(0, 1'b1, 1'b1, 8'd5, 7'd5, 3'd7);
      set_src(1, 1'b1, 1'b0, 8'd100, 7'd50, 3'd3);
      step(2'b00, 1'b0, "stall arb");
      for (int p = 0; p < 5; p++) begin
         set_src(1, 1'b1, (p == 4), 8'(100 + p), 7'd50, 3'd3);
         step(2'b10, 1'b1, "stall pixel");
         if (p == 1) begin
            set_src(1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
            repeat (4) step(2'b00, 1'b1, "stalled");
         end
      end
      step(2'b00, 1'b0, "stall gap");
      step(2'b01, 1'b1, "src0 after stall");
      set_src(0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      set_src(1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      step(2'b00, 1'b0, "stall end");

      // ---------------- off-screen y values ----------------
      set_src(0, 1'b1, 1'b0, 8'd60, 7'd118, 3'd5);
      step(2'b00, 1'b0, "bnd arb");
      step(2'b01, 1'b1, "bnd y118");
      set_src(0, 1'b1, 1'b0, 8'd60, 7'd120, 3'd5);
      step(2'b01, 1'b1, "bnd y120");
      set_src(0, 1'b1, 1'b1, 8'd60, 7'd121, 3'd5);
      step(2'b01, 1'b1, "bnd y121");
      set_src(0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      step(2'b00, 1'b0, "bnd end");

      // ---------------- reset in the middle of a burst ----------------
      set_src(0, 1'b1, 1'b0, 8'd60, 7'd40, 3'd6);
      step(2'b00, 1'b0, "mid arb");
      for (int p = 0; p < 10; p++) begin
         set_src(0, 1'b1, 1'b0, 8'(60 + p), 7'd40, 3'd6);
         step(2'b01, 1'b1, "mid pixel");
      end
      set_src(0, 1'b1, 1'b0, 8'd70, 7'd40, 3'd6);
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1 check_cleared("async reset");
      repeat (2) @(negedge clock);
      set_src(0, 1'b1, 1'b1, 8'd1, 7'd2, 3'd3);
      set_src(1, 1'b1, 1'b1, 8'd4, 7'd5, 3'd6);
      reset_n = 1'b1;
      @(posedge clock); #1;
      step(2'b01, 1'b1, "post reset grant src0");
      set_src(0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      set_src(1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      step(2'b00, 1'b0, "post reset idle");

      repeat (3) @(negedge clock);
      chk("scoreboard drained", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
